// File: rtl/mirfak_writeback_arbiter_if.sv
// Bus bundle for the register-file writeback arbiter: both request sources, the
// issue/scoreboard port, FIFO status and the register-file write port.
interface mirfak_writeback_arbiter_if #(
    parameter int FIFO_DEPTH = 2
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic             a_valid_i;
    logic [4:0]       a_waddr_i;
    logic [31:0]      a_wdata_i;
    logic             a_stall_o;
    logic             b_valid_i;
    logic [4:0]       b_waddr_i;
    logic [31:0]      b_wdata_i;
    logic             b_ready_o;
    logic             issue_i;
    logic [4:0]       issue_waddr_i;
    logic [31:0]      busy_o;
    logic [CNT_W-1:0] fifo_count_o;
    logic [4:0]       waddr_o;
    logic [31:0]      wdata_o;
    logic             wen_o;

    // The arbiter sits on the slave side; the pipeline / register file is the master.
    modport slave (
        input  a_valid_i, a_waddr_i, a_wdata_i,
        input  b_valid_i, b_waddr_i, b_wdata_i,
        input  issue_i, issue_waddr_i,
        output a_stall_o, b_ready_o, busy_o, fifo_count_o,
        output waddr_o, wdata_o, wen_o
    );

    modport master (
        output a_valid_i, a_waddr_i, a_wdata_i,
        output b_valid_i, b_waddr_i, b_wdata_i,
        output issue_i, issue_waddr_i,
        input  a_stall_o, b_ready_o, busy_o, fifo_count_o,
        input  waddr_o, wdata_o, wen_o
    );
endinterface

// File: rtl/mirfak_writeback_arbiter.sv
// Merges the in-order commit stream (A) and a FIFO-buffered long-latency stream (B)
// onto the single register-file write port, with a busy scoreboard for B destinations.
module mirfak_writeback_arbiter #(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    mirfak_writeback_arbiter_if.slave  bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_entry_t;

    wb_entry_t        fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [STV_W-1:0] starve_q, starve_d;
    logic             wen_q, wen_d;
    logic             bsrc_q, bsrc_d;
    logic [4:0]       waddr_q, waddr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      busy_q, busy_d;

    logic      fifo_empty;
    logic      b_ready;
    logic      push;
    logic      force_b;
    logic      sel_a;
    logic      sel_b;
    wb_entry_t sel;

    // Ready comes from the registered count only, so a full FIFO never accepts
    // even if the head is being popped in the same cycle.
    assign fifo_empty = (count_q == '0);
    assign b_ready    = (count_q != CNT_W'(FIFO_DEPTH));
    assign push       = bus.b_valid_i && b_ready;
    assign force_b    = (starve_q == STV_W'(STARVE_LIMIT)) && !fifo_empty;
    assign sel_b      = force_b || (!bus.a_valid_i && !fifo_empty);
    assign sel_a      = !sel_b && bus.a_valid_i;

    always_comb begin
        sel = '0;
        if (sel_b) begin
            sel = fifo_mem_q[rd_ptr_q];
        end else if (sel_a) begin
            sel.addr = bus.a_waddr_i;
            sel.data = bus.a_wdata_i;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(sel_b);
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (sel_b) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        // Counts A wins only while B is waiting; any B service or empty FIFO resets it.
        starve_d = starve_q;
        if (sel_b || fifo_empty) begin
            starve_d = '0;
        end else if (sel_a && (starve_q != STV_W'(STARVE_LIMIT))) begin
            starve_d = starve_q + STV_W'(1);
        end

        wen_d   = (sel_a || sel_b) && (sel.addr != 5'd0);
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (sel_a || sel_b) begin
            waddr_d = sel.addr;
            wdata_d = sel.data;
        end
        bsrc_d = sel_b;

        // Clear first so that a same-edge issue to the retiring register wins.
        busy_d = busy_q;
        if (wen_q && bsrc_q) begin
            busy_d[waddr_q] = 1'b0;
        end
        if (bus.issue_i && (bus.issue_waddr_i != 5'd0)) begin
            busy_d[bus.issue_waddr_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            wen_q    <= 1'b0;
            bsrc_q   <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            busy_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            wen_q    <= wen_d;
            bsrc_q   <= bsrc_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            busy_q   <= busy_d;
        end
    end

    // Storage needs no reset: the pointers and count define which entries are live.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= '{addr: bus.b_waddr_i, data: bus.b_wdata_i};
        end
    end

    assign bus.a_stall_o    = force_b && bus.a_valid_i;
    assign bus.b_ready_o    = b_ready;
    assign bus.busy_o       = busy_q;
    assign bus.fifo_count_o = count_q;
    assign bus.waddr_o      = waddr_q;
    assign bus.wdata_o      = wdata_q;
    assign bus.wen_o        = wen_q;
endmodule

// File: tb/tb_mirfak_writeback_arbiter.sv
// Directed bench for mirfak_writeback_arbiter: a queue-based model is compared every
// cycle, and literal expectations from hand-worked scenarios pin the model.
module tb_mirfak_writeback_arbiter;
    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    mirfak_writeback_arbiter_if #(.FIFO_DEPTH(DEPTH)) bus ();

    mirfak_writeback_arbiter #(
        .FIFO_DEPTH  (DEPTH),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t        mq[$];
    int          m_starve;
    logic [31:0] m_busy;
    logic        m_wen;
    logic        m_bsrc;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;

    task automatic model_reset();
        mq.delete();
        m_starve = 0;
        m_busy   = '0;
        m_wen    = 1'b0;
        m_bsrc   = 1'b0;
        m_waddr  = '0;
        m_wdata  = '0;
    endtask

    task automatic model_step();
        int   sz;
        bit   ready;
        bit   take_b;
        bit   take_a;
        ent_t s;
        sz     = mq.size();
        ready  = (sz != DEPTH);
        take_b = ((m_starve == LIMIT) && sz > 0) || (!bus.a_valid_i && sz > 0);
        take_a = !take_b && bus.a_valid_i;
        s      = '0;
        if (m_wen && m_bsrc) m_busy[m_waddr] = 1'b0;
        if (bus.issue_i && bus.issue_waddr_i != 0) m_busy[bus.issue_waddr_i] = 1'b1;
        m_busy[0] = 1'b0;
        if (take_b || sz == 0) m_starve = 0;
        else if (take_a && m_starve < LIMIT) m_starve++;
        if (take_b) s = mq.pop_front();
        else if (take_a) s = '{a: bus.a_waddr_i, d: bus.a_wdata_i};
        m_wen = (take_a || take_b) && (s.a != 0);
        if (take_a || take_b) begin
            m_waddr = s.a;
            m_wdata = s.d;
        end
        m_bsrc = take_b;
        if (bus.b_valid_i && ready) mq.push_back('{a: bus.b_waddr_i, d: bus.b_wdata_i});
    endtask

    // Single compare process: registered outputs after each edge, combinational
    // handshake outputs mid-cycle once the stimulus has settled.
    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (!rst_n) model_reset();
            else model_step();
            #1;
            check("m_wen",   {31'd0, bus.wen_o}, {31'd0, m_wen});
            check("m_waddr", {27'd0, bus.waddr_o}, {27'd0, m_waddr});
            check("m_wdata", bus.wdata_o, m_wdata);
            check("m_busy",  bus.busy_o, m_busy);
            check("m_count", 32'(bus.fifo_count_o), 32'(mq.size()));
            @(negedge clk);
            #1;
            check("m_stall", {31'd0, bus.a_stall_o},
                  {31'd0, (m_starve == LIMIT) && (mq.size() > 0) && bus.a_valid_i});
            check("m_ready", {31'd0, bus.b_ready_o}, {31'd0, mq.size() != DEPTH});
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle();
        bus.a_valid_i     = 1'b0;
        bus.a_waddr_i     = '0;
        bus.a_wdata_i     = '0;
        bus.b_valid_i     = 1'b0;
        bus.b_waddr_i     = '0;
        bus.b_wdata_i     = '0;
        bus.issue_i       = 1'b0;
        bus.issue_waddr_i = '0;
    endtask

    task automatic drive_a(input logic [4:0] a, input logic [31:0] d);
        bus.a_valid_i = 1'b1;
        bus.a_waddr_i = a;
        bus.a_wdata_i = d;
    endtask

    task automatic drive_b(input logic [4:0] a, input logic [31:0] d);
        bus.b_valid_i = 1'b1;
        bus.b_waddr_i = a;
        bus.b_wdata_i = d;
    endtask

    task automatic drive_issue(input logic [4:0] a);
        bus.issue_i       = 1'b1;
        bus.issue_waddr_i = a;
    endtask

    initial begin
        int k;
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        idle();
        tick();
        tick();
        check("rst_wen",   {31'd0, bus.wen_o}, 32'd0);
        check("rst_busy",  bus.busy_o, 32'd0);
        check("rst_count", 32'(bus.fifo_count_o), 32'd0);
        check("rst_ready", {31'd0, bus.b_ready_o}, 32'd1);
        check("rst_wdata", bus.wdata_o, 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: single A write
        $display("TXN 1: A write x5 <= 0xDEADBEEF");
        drive_a(5'd5, 32'hDEADBEEF);
        #1 check("t1_stall", {31'd0, bus.a_stall_o}, 32'd0);
        tick();
        idle();
        check("t1_wen",   {31'd0, bus.wen_o}, 32'd1);
        check("t1_waddr", {27'd0, bus.waddr_o}, 32'd5);
        check("t1_wdata", bus.wdata_o, 32'hDEADBEEF);
        tick();
        check("t1_wen_off", {31'd0, bus.wen_o}, 32'd0);

        // 2: B write with scoreboard
        $display("TXN 2: issue x7, B write x7 <= 0x1234");
        drive_issue(5'd7);
        tick();
        idle();
        check("t2_busy_set", {31'd0, bus.busy_o[7]}, 32'd1);
        drive_b(5'd7, 32'h1234);
        tick();
        idle();
        tick();
        check("t2_wen",   {31'd0, bus.wen_o}, 32'd1);
        check("t2_waddr", {27'd0, bus.waddr_o}, 32'd7);
        check("t2_wdata", bus.wdata_o, 32'h1234);
        check("t2_busy_hold", {31'd0, bus.busy_o[7]}, 32'd1);
        tick();
        check("t2_busy_clr", {31'd0, bus.busy_o[7]}, 32'd0);

        // 3: FIFO full with A holding the port
        $display("TXN 3: fill FIFO under continuous A, third B push held");
        drive_a(5'd1, 32'h11);
        drive_b(5'd2, 32'h22);
        tick();
        drive_b(5'd3, 32'h33);
        tick();
        drive_b(5'd4, 32'h44);
        check("t3_count", 32'(bus.fifo_count_o), 32'd2);
        check("t3_ready", {31'd0, bus.b_ready_o}, 32'd0);
        k = 0;
        while (!bus.b_ready_o && k < 20) begin
            tick();
            k++;
        end
        check("t3_ready_again", {31'd0, bus.b_ready_o}, 32'd1);
        tick();
        idle();
        tick();
        tick();
        tick();
        check("t3_drained", 32'(bus.fifo_count_o), 32'd0);

        // 4: starvation forces B
        $display("TXN 4: B x9 <= 0xA5 waits behind continuous A");
        drive_a(5'd10, 32'hAA);
        drive_b(5'd9, 32'hA5);
        tick();
        bus.b_valid_i = 1'b0;
        for (int i = 0; i < LIMIT; i++) begin
            check("t4_no_stall", {31'd0, bus.a_stall_o}, 32'd0);
            tick();
        end
        check("t4_stall", {31'd0, bus.a_stall_o}, 32'd1);
        tick();
        check("t4_b_wen",   {31'd0, bus.wen_o}, 32'd1);
        check("t4_b_waddr", {27'd0, bus.waddr_o}, 32'd9);
        check("t4_b_wdata", bus.wdata_o, 32'hA5);
        check("t4_unstall", {31'd0, bus.a_stall_o}, 32'd0);
        tick();
        check("t4_a_resume", {27'd0, bus.waddr_o}, 32'd10);
        idle();
        tick();

        // 5a: x0 writes from both sources
        $display("TXN 5a: A and B writes to x0, issue to x0");
        drive_a(5'd0, 32'h1);
        drive_b(5'd0, 32'h2);
        drive_issue(5'd0);
        tick();
        idle();
        check("t5_x0_a_wen", {31'd0, bus.wen_o}, 32'd0);
        tick();
        check("t5_x0_b_wen", {31'd0, bus.wen_o}, 32'd0);
        check("t5_x0_drain", 32'(bus.fifo_count_o), 32'd0);
        check("t5_busy0",    {31'd0, bus.busy_o[0]}, 32'd0);

        // 5b: issue collides with retirement of the same register
        $display("TXN 5b: issue x3 on the edge B write x3 retires");
        drive_issue(5'd3);
        tick();
        idle();
        drive_b(5'd3, 32'h33);
        tick();
        idle();
        tick();
        check("t5_col_wen", {31'd0, bus.wen_o}, 32'd1);
        drive_issue(5'd3);
        tick();
        idle();
        check("t5_col_busy", {31'd0, bus.busy_o[3]}, 32'd1);

        // 6: asynchronous reset mid-operation
        $display("TXN 6: retire x3, busy x7/x8, fill FIFO, async reset");
        drive_b(5'd3, 32'h3);
        drive_issue(5'd7);
        tick();
        bus.b_valid_i = 1'b0;
        drive_issue(5'd8);
        tick();
        idle();
        tick();
        drive_a(5'd1, 32'h5);
        drive_b(5'd20, 32'h20);
        tick();
        drive_b(5'd21, 32'h21);
        tick();
        bus.b_valid_i = 1'b0;
        check("t6_pre_count", 32'(bus.fifo_count_o), 32'd2);
        check("t6_pre_busy",  bus.busy_o, 32'h00000180);
        check("t6_pre_wen",   {31'd0, bus.wen_o}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_wen",   {31'd0, bus.wen_o}, 32'd0);
        check("t6_rst_busy",  bus.busy_o, 32'd0);
        check("t6_rst_count", 32'(bus.fifo_count_o), 32'd0);
        check("t6_rst_ready", {31'd0, bus.b_ready_o}, 32'd1);
        tick();
        idle();
        tick();
        rst_n = 1'b1;
        drive_a(5'd6, 32'h66);
        tick();
        idle();
        check("t6_post_waddr", {27'd0, bus.waddr_o}, 32'd6);
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
